rule_enable_scheduler: RTL and testbench

// Upstream driver for the generated protocol `system` model. Each cycle it

---
 rtl/rule_enable_scheduler_if.sv | 28 ++
 rtl/rule_enable_scheduler.sv | 125 ++++++++++++
 tb/tb_rule_enable_scheduler.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/rule_enable_scheduler_if.sv
// Bus between the rule-enable scheduler and its driver/observer.
// Handshake: en_valid qualifies en_out (high exactly when en_out is nonzero);
// the protocol model consumes every enable, so there is no ready back-pressure.
interface rule_enable_scheduler_if #(
  parameter int NUM_RULES = 4,
  parameter int CNT_W     = 16
);
  logic                 start;
  logic                 stop;
  logic                 stall;
  logic                 mode;
  logic [NUM_RULES-1:0] guard;
  logic [NUM_RULES-1:0] en_out;
  logic                 en_valid;
  logic                 deadlock;
  logic [CNT_W-1:0]     fire_count;
  logic [1:0]           state;

  modport master (
    output start, stop, stall, mode, guard,
    input  en_out, en_valid, deadlock, fire_count, state
  );

  modport slave (
    input  start, stop, stall, mode, guard,
    output en_out, en_valid, deadlock, fire_count, state
  );
endinterface

// File: rtl/rule_enable_scheduler.sv
// Picks at most one enabled Murphi rule per cycle (round-robin or LFSR start
// point) and drives it one-hot to the system model; flags guard deadlock.
module rule_enable_scheduler #(
  parameter int          NUM_RULES      = 4,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          DEADLOCK_LIMIT = 8,
  parameter int          CNT_W          = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  rule_enable_scheduler_if.slave   bus
);
  localparam int IDX_W  = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1;
  localparam int IDLE_W = $clog2(DEADLOCK_LIMIT + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_HOLD     = 2'd2,
    S_DEADLOCK = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_RULES-1:0] en_q;
  logic                 deadlock_q;
  logic [CNT_W-1:0]     fire_q;
  logic [IDX_W-1:0]     rr_q;
  logic [15:0]          lfsr_q;
  logic [IDLE_W-1:0]    idle_q;

  logic [IDX_W-1:0]     base, lfsr_mod, grant_idx, rr_next;
  logic                 grant_found, do_grant, idle_tick, idle_hit, enter_run;
  logic [NUM_RULES-1:0] grant_onehot;
  logic [15:0]          lfsr_next;

  // Galois form, taps 16,14,13,11: the all-zero state is unreachable from a nonzero seed.
  assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  assign lfsr_mod  = IDX_W'(32'(lfsr_q) % NUM_RULES);

  always_comb begin
    logic [IDX_W-1:0] scan;
    base        = bus.mode ? lfsr_mod : rr_q;
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = '0;
    for (int i = 0; i < NUM_RULES; i++) begin
      scan = IDX_W'((32'(base) + i) % NUM_RULES);
      if (!grant_found && bus.guard[scan]) begin
        grant_found = 1'b1;
        grant_idx   = scan;
      end
    end
  end

  assign do_grant     = (state_q == S_RUN) && !bus.stall && !bus.stop && grant_found;
  assign grant_onehot = {{(NUM_RULES-1){1'b0}}, 1'b1} << grant_idx;
  assign rr_next      = (grant_idx == IDX_W'(NUM_RULES - 1)) ? '0 : grant_idx + 1'b1;
  // start clears idle_cnt, so a start cycle never counts toward deadlock.
  assign idle_tick    = (state_q == S_RUN) && !bus.stall && !bus.stop && !bus.start &&
                        (bus.guard == '0);
  assign idle_hit     = idle_tick && (idle_q == IDLE_W'(DEADLOCK_LIMIT - 1));
  assign enter_run    = bus.start && !bus.stop &&
                        ((state_q == S_IDLE) || (state_q == S_DEADLOCK));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (enter_run) state_d = S_RUN;
      S_RUN: begin
        if (bus.stop)       state_d = S_IDLE;
        else if (bus.stall) state_d = S_HOLD;
        else if (idle_hit)  state_d = S_DEADLOCK;
      end
      S_HOLD: begin
        if (bus.stop)        state_d = S_IDLE;
        else if (!bus.stall) state_d = S_RUN;
      end
      S_DEADLOCK: begin
        if (bus.stop)       state_d = S_IDLE;
        else if (enter_run) state_d = S_RUN;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      en_q       <= '0;
      deadlock_q <= 1'b0;
      fire_q     <= '0;
      rr_q       <= '0;
      lfsr_q     <= LFSR_SEED;
      idle_q     <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= do_grant ? grant_onehot : '0;

      if (state_d == S_DEADLOCK && state_q != S_DEADLOCK) deadlock_q <= 1'b1;
      else if (enter_run)                                 deadlock_q <= 1'b0;

      if (bus.start) begin
        lfsr_q <= LFSR_SEED;
        rr_q   <= '0;
        idle_q <= '0;
        fire_q <= '0;
      end else begin
        if (state_q == S_RUN) lfsr_q <= lfsr_next;
        if (do_grant) begin
          rr_q   <= rr_next;
          idle_q <= '0;
          if (fire_q != '1) fire_q <= fire_q + 1'b1;
        end else if (idle_tick) begin
          idle_q <= idle_q + 1'b1;
        end
      end
    end
  end

  assign bus.en_out     = en_q;
  assign bus.en_valid   = |en_q;
  assign bus.deadlock   = deadlock_q;
  assign bus.fire_count = fire_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_rule_enable_scheduler.sv
// Directed bench for rule_enable_scheduler: expected grants go into a queue,
// a negedge monitor pops and compares whenever en_valid is high.
module tb_rule_enable_scheduler;
  localparam int NR = 4;
  localparam int CW = 16;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_HOLD = 2'd2, ST_DEAD = 2'd3;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  rule_enable_scheduler_if #(.NUM_RULES(NR), .CNT_W(CW)) bus ();

  rule_enable_scheduler #(
    .NUM_RULES(NR), .LFSR_SEED(16'hACE1), .DEADLOCK_LIMIT(8), .CNT_W(CW)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  logic [NR-1:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  logic [NR-1:0] seq_a[16];
  logic [NR-1:0] seq_b[16];
  logic [NR-1:0] seen;
  logic [15:0]   lfsr_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock of stimulus; a nonzero exp is the enable due after this edge.
  task automatic drive(input logic st, input logic sp, input logic sl,
                       input logic [NR-1:0] g, input logic [NR-1:0] exp);
    bus.start = st;
    bus.stop  = sp;
    bus.stall = sl;
    bus.guard = g;
    if (exp != '0) exp_q.push_back(exp);
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  always @(negedge clock) begin
    if (reset_n === 1'b1 && bus.en_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_grant: got %b expected none", bus.en_out);
      end else begin
        logic [NR-1:0] e;
        e = exp_q.pop_front();
        check("grant", 32'(bus.en_out), 32'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.stall = 1'b0;
    bus.mode  = 1'b0;
    bus.guard = 4'b1111;
    seen      = '0;

    // T1 reset
    repeat (3) @(posedge clock);
    #1;
    check("rst_en_out",   32'(bus.en_out), 32'h0);
    check("rst_en_valid", 32'(bus.en_valid), 32'h0);
    check("rst_fire",     32'(bus.fire_count), 32'h0);
    check("rst_deadlock", 32'(bus.deadlock), 32'h0);
    check("rst_state",    32'(bus.state), 32'(ST_IDLE));
    reset_n = 1'b1;
    repeat (3) drive(0, 0, 0, 4'b1111, 4'b0000);
    check("idle_no_grant", 32'(bus.en_out), 32'h0);
    check("idle_state",    32'(bus.state), 32'(ST_IDLE));

    // T2 round-robin
    drive(1, 0, 0, 4'b0000, 4'b0000);
    check("start_state", 32'(bus.state), 32'(ST_RUN));
    drive(0, 0, 0, 4'b1111, 4'b0001);
    drive(0, 0, 0, 4'b1111, 4'b0010);
    drive(0, 0, 0, 4'b1111, 4'b0100);
    drive(0, 0, 0, 4'b1111, 4'b1000);
    drive(0, 0, 0, 4'b1111, 4'b0001);
    check("rr_fire5", 32'(bus.fire_count), 32'd5);

    // T3 skip: rr_ptr is 1 here
    drive(0, 0, 0, 4'b1001, 4'b1000);
    drive(0, 0, 0, 4'b1001, 4'b0001);
    drive(0, 0, 0, 4'b0000, 4'b0000);
    check("skip_zero_en",    32'(bus.en_out), 32'h0);
    check("skip_zero_valid", 32'(bus.en_valid), 32'h0);
    check("skip_fire7",      32'(bus.fire_count), 32'd7);

    // T4 deadlock
    drive(1, 0, 0, 4'b0000, 4'b0000);
    check("restart_fire0", 32'(bus.fire_count), 32'd0);
    repeat (7) drive(0, 0, 0, 4'b0000, 4'b0000);
    check("dl_before_limit", 32'(bus.deadlock), 32'h0);
    drive(0, 0, 0, 4'b0000, 4'b0000);
    check("dl_flag",  32'(bus.deadlock), 32'h1);
    check("dl_state", 32'(bus.state), 32'(ST_DEAD));
    drive(0, 0, 0, 4'b0001, 4'b0000);
    drive(0, 0, 0, 4'b0001, 4'b0000);
    check("dl_no_grant", 32'(bus.en_out), 32'h0);
    check("dl_sticky",   32'(bus.deadlock), 32'h1);
    drive(1, 0, 0, 4'b0001, 4'b0000);
    check("dl_cleared",  32'(bus.deadlock), 32'h0);
    check("dl_restart",  32'(bus.state), 32'(ST_RUN));

    // T5 stall freezes idle_cnt: 5 idle + 2 idle stays below the limit of 8
    repeat (5) drive(0, 0, 0, 4'b0000, 4'b0000);
    drive(0, 0, 1, 4'b0100, 4'b0000);
    drive(0, 0, 1, 4'b0000, 4'b0000);
    drive(0, 0, 1, 4'b0000, 4'b0000);
    check("stall_en_out", 32'(bus.en_out), 32'h0);
    check("stall_state",  32'(bus.state), 32'(ST_HOLD));
    drive(0, 0, 0, 4'b0100, 4'b0000);
    check("unstall_state", 32'(bus.state), 32'(ST_RUN));
    drive(0, 0, 0, 4'b0000, 4'b0000);
    drive(0, 0, 0, 4'b0000, 4'b0000);
    check("stall_froze_idle", 32'(bus.deadlock), 32'h0);
    drive(0, 0, 0, 4'b0100, 4'b0100);
    check("stall_fire1", 32'(bus.fire_count), 32'd1);
    drive(0, 1, 0, 4'b1111, 4'b0000);
    check("stop_state",  32'(bus.state), 32'(ST_IDLE));
    check("stop_no_grant", 32'(bus.en_out), 32'h0);

    // T6 LFSR mode: two identical runs from the seed
    bus.mode = 1'b1;
    drive(1, 0, 0, 4'b0000, 4'b0000);
    lfsr_m = 16'hACE1;
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 4'b1111, 4'(1 << lfsr_m[1:0]));
      lfsr_m   = lfsr_step(lfsr_m);
      seq_a[i] = bus.en_out;
      seen     = seen | bus.en_out;
      check("lfsr_onehot_a", 32'($onehot(bus.en_out)), 32'h1);
    end
    check("lfsr_all_rules", 32'(seen), 32'hF);
    drive(0, 1, 0, 4'b0000, 4'b0000);
    drive(1, 0, 0, 4'b0000, 4'b0000);
    lfsr_m = 16'hACE1;
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 4'b1111, 4'(1 << lfsr_m[1:0]));
      lfsr_m   = lfsr_step(lfsr_m);
      seq_b[i] = bus.en_out;
    end
    for (int i = 0; i < 16; i++) check("lfsr_repeat", 32'(seq_b[i]), 32'(seq_a[i]));

    // asynchronous reset while an enable is held
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check("async_rst_en",    32'(bus.en_out), 32'h0);
    check("async_rst_valid", 32'(bus.en_valid), 32'h0);
    check("async_rst_state", 32'(bus.state), 32'(ST_IDLE));
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (2) drive(0, 0, 0, 4'b0000, 4'b0000);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
